// File: rtl/mem_responder.sv
// mem_responder
//   Two-port (A and B) memory responder in front of a single-port RAM.
//   Only one RAM operation happens per clock. The order of priority is:
//   A write, then buffered B write, then live B write, then A read, then B read.
//   A B write that loses arbitration is parked in a one-entry buffer.
//   A read is issued only in a cycle with no pending write of any kind.
//   Its ack and data appear exactly one cycle after issue.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   a_mem_read / a_mem_read_idx    port A read request and address
//   a_mem_read_byte / a_mem_read_ack  port A read data (valid with ack), ack pulse
//   a_mem_write / _idx / _byte     port A single-cycle write strobe, address, data
//   b_mem_*                        port B, same meaning as port A
//   wr_overflow                    sticky: a port B write was dropped
module mem_responder #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_mem_read,
   input  logic [ADDR_W-1:0] a_mem_read_idx,
   output logic [DATA_W-1:0] a_mem_read_byte,
   output logic              a_mem_read_ack,
   input  logic              a_mem_write,
   input  logic [ADDR_W-1:0] a_mem_write_idx,
   input  logic [DATA_W-1:0] a_mem_write_byte,
   input  logic              b_mem_read,
   input  logic [ADDR_W-1:0] b_mem_read_idx,
   output logic [DATA_W-1:0] b_mem_read_byte,
   output logic              b_mem_read_ack,
   input  logic              b_mem_write,
   input  logic [ADDR_W-1:0] b_mem_write_idx,
   input  logic [DATA_W-1:0] b_mem_write_byte,
   output logic              wr_overflow
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] ram_q;

   logic              a_ack_reg;
   logic              b_ack_reg;
   logic              overflow_reg;
   logic              buf_valid_reg;
   logic [ADDR_W-1:0] buf_idx_reg;
   logic [DATA_W-1:0] buf_byte_reg;

   logic              any_write;
   logic              a_issue;
   logic              b_issue;
   logic [ADDR_W-1:0] wr_idx;
   logic [DATA_W-1:0] wr_byte;
   logic [ADDR_W-1:0] rd_idx;

   // The ack register also serves as the in-flight flag. A port whose ack
   // is currently showing is the port that was issued last cycle, so its
   // request (still held by the requester) must not re-issue.
   always_comb begin
      any_write = a_mem_write | buf_valid_reg | b_mem_write;
      a_issue   = !any_write && a_mem_read && !a_ack_reg;
      b_issue   = !any_write && b_mem_read && !b_ack_reg && !a_issue;
      rd_idx    = a_issue ? a_mem_read_idx : b_mem_read_idx;

      wr_idx  = b_mem_write_idx;
      wr_byte = b_mem_write_byte;
      if (a_mem_write) begin
         wr_idx  = a_mem_write_idx;
         wr_byte = a_mem_write_byte;
      end else if (buf_valid_reg) begin
         wr_idx  = buf_idx_reg;
         wr_byte = buf_byte_reg;
      end
   end

   // Single-port RAM with a registered read. It has no reset, so its
   // contents survive reset.
   always_ff @(posedge clk) begin
      if (any_write) begin
         mem[wr_idx] <= wr_byte;
      end else if (a_issue || b_issue) begin
         ram_q <= mem[rd_idx];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_ack_reg     <= 1'b0;
         b_ack_reg     <= 1'b0;
         overflow_reg  <= 1'b0;
         buf_valid_reg <= 1'b0;
         buf_idx_reg   <= '0;
         buf_byte_reg  <= '0;
      end else begin
         a_ack_reg <= a_issue;
         b_ack_reg <= b_issue;
         if (a_mem_write) begin
            // A owns the RAM this cycle. A live B write goes into the
            // buffer if the buffer is free; otherwise it is dropped.
            if (b_mem_write) begin
               if (buf_valid_reg) begin
                  overflow_reg <= 1'b1;
               end else begin
                  buf_valid_reg <= 1'b1;
                  buf_idx_reg   <= b_mem_write_idx;
                  buf_byte_reg  <= b_mem_write_byte;
               end
            end
         end else if (buf_valid_reg) begin
            // The buffer drains this cycle. A live B write takes its
            // place, so the buffer stays full.
            if (b_mem_write) begin
               buf_idx_reg  <= b_mem_write_idx;
               buf_byte_reg <= b_mem_write_byte;
            end else begin
               buf_valid_reg <= 1'b0;
            end
         end
      end
   end

   assign a_mem_read_ack  = a_ack_reg;
   assign b_mem_read_ack  = b_ack_reg;
   assign a_mem_read_byte = a_ack_reg ? ram_q : '0;
   assign b_mem_read_byte = b_ack_reg ? ram_q : '0;
   assign wr_overflow     = overflow_reg;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 12: byte address width; RAM depth is 2**ADDR_W bytes.
REQ-002 Parameter DATA_W, default 8: data byte width.
REQ-003 clk  in  1: single clock; all state changes on rising edge.
REQ-004 rst_n  in  1: reset, asynchronous and active-low.
REQ-005 a_mem_read  in  1: port A read request, held high until a_mem_read_ack.
REQ-006 a_mem_read_idx  in  ADDR_W: port A read address.
REQ-007 a_mem_read_byte  out  DATA_W: port A read data, valid only while a_mem_read_ack=1.
REQ-008 a_mem_read_ack  out  1: port A one-cycle read acknowledge.
REQ-009 a_mem_write  in  1: port A single-cycle write strobe; never stalled, never acknowledged.
REQ-010 a_mem_write_idx  in  ADDR_W: port A write address.
REQ-011 a_mem_write_byte  in  DATA_W: port A write data.
REQ-012 b_mem_read, b_mem_read_idx, b_mem_read_byte, b_mem_read_ack, b_mem_write, b_mem_write_idx, b_mem_write_byte: port B, same directions, widths and meanings as REQ-005..REQ-011.
REQ-013 wr_overflow  out  1: sticky flag, port B write dropped.

Function
REQ-014 Internal single-port RAM; at most one RAM operation (read or write) per clock.
REQ-015 Per-cycle priority: A live write > B buffered write > B live write > A read > B read.
REQ-016 Writes on either port accepted in the strobe cycle; requester is never stalled.
REQ-017 B write losing arbitration is captured in a 1-entry B write buffer (addr+data).
REQ-018 B live write while buffer full and buffer drains that cycle: live write replaces buffer contents; buffer stays full.
REQ-019 B live write while buffer full and A live write same cycle: new B write dropped, buffer kept, wr_overflow set to 1 until reset.
REQ-020 No read issues in a cycle where any write (live or buffered) is pending; all accepted writes reach RAM before any later-issued read.
REQ-021 Same-address A and B writes in one cycle: A written first, B later; final RAM value is B's data.
REQ-022 Read issue: address sampled in issue cycle; port marked in-flight; ack+data driven exactly one cycle later.
REQ-023 Minimum read latency: request high in cycle N with no conflict -> ack=1 and data valid in cycle N+1.
REQ-024 Ack is a one-cycle pulse; ack=0 and read_byte=0 in all other cycles.
REQ-025 In-flight port: read request ignored until its ack cycle; no re-issue in the ack cycle even if request still high.
REQ-026 Requester may issue a new read from cycle after ack; back-to-back reads on one port sustain one ack per 2 cycles.
REQ-027 Simultaneous A and B reads: A issues in cycle N (ack N+1), B issues N+1 (ack N+2).
REQ-028 Request dropped after issue (protocol violation): ack still delivered with sampled-address data.
REQ-029 Reads may starve under continuous writes; no fairness guarantee.
REQ-030 Address arithmetic unsigned, ADDR_W wide; no out-of-range addresses exist.

Reset
REQ-031 rst_n=0 forces asynchronously: both acks 0, both read_bytes 0, wr_overflow 0, B buffer empty, in-flight flags clear.
REQ-032 RAM contents not cleared by reset.
REQ-033 Read in flight at reset assertion: no ack produced after release.
REQ-034 Buffered B write at reset assertion: discarded, never written.
REQ-035 First request honoured on first rising edge with rst_n=1.

Verification
REQ-036 A write 0x100<=0x5A cycle 0; A read 0x100 cycle 1 -> a_mem_read_ack=1, a_mem_read_byte=0x5A in cycle 2.
REQ-037 A and B write 0x200 (0x11, 0x22) same cycle; A read 0x200 next cycle -> read issues only after B buffer drains; returns 0x22.
REQ-038 A and B read 0x010 (holding 0xC3) in cycle N -> A ack N+1, B ack N+2, both 0xC3; no duplicate acks with requests held through ack.
REQ-039 B write while buffer full and A write same cycle -> wr_overflow=1, dropped data absent from RAM, earlier buffered write present.
REQ-040 GPU-style sequence: read 0x300 -> 0xF0, read 0x108 -> 0x3C, write 0x108<=0xCC; readback 0x108 -> 0xCC; each ack exactly one cycle.
REQ-041 rst_n low one cycle after A read issue -> no ack after release; outputs 0; RAM data preserved on later read.
